proc_multiciclo_param: RTL and testbench



---
 rtl/proc_multiciclo_param.sv | 99 +++++++++
 tb/tb_proc_multiciclo_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/proc_multiciclo_param.sv
// Parametrised multicycle processor: fetches one instruction word on Run,
// then executes it over 1-3 control steps on a shared bus.
module proc_multiciclo_param #(
  parameter int N    = 16,
  parameter int NREG = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  output logic         Done,
  output logic         Err,
  output logic [N-1:0] BusWires
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(N);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]            step;
  logic [N-1:0]          ir, a, g, alu;
  logic [NREG-1:0][N-1:0] r;
  logic [3:0]            op;
  logic [RW-1:0]         x, y;
  logic                  rx_we, a_we, g_we;

  assign op = ir[N-1 -: 4];
  assign x  = ir[N-5 -: RW];
  assign y  = ir[N-5-RW -: RW];

  // Low IR bits below the Y field carry no meaning.
  if (N > 4 + 2*RW) begin : g_ir_tail
    logic unused_ir_tail;
    assign unused_ir_tail = ^ir[N-5-2*RW:0];
  end

  // ALU result sampled into G at the end of T2, when the bus carries Ry.
  always_comb begin
    alu = '0;
    case (op)
      4'd2:    alu = a + BusWires;
      4'd3:    alu = a - BusWires;
      4'd4:    alu = a & BusWires;
      4'd5:    alu = {{(N-1){1'b0}}, ($signed(a) < $signed(BusWires))};
      4'd6:    alu = a << BusWires[SW-1:0];
      default: alu = '0;
    endcase
  end

  always_comb begin
    BusWires = '0;
    Done     = 1'b0;
    Err      = 1'b0;
    rx_we    = 1'b0;
    a_we     = 1'b0;
    g_we     = 1'b0;
    case (step)
      T1: begin
        case (op)
          4'd0: begin BusWires = r[y]; rx_we = 1'b1; Done = 1'b1; end
          4'd1: begin BusWires = DIN;  rx_we = 1'b1; Done = 1'b1; end
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            BusWires = r[x];
            a_we     = 1'b1;
          end
          4'd7: begin BusWires = r[y]; rx_we = (g != '0); Done = 1'b1; end
          default: begin Done = 1'b1; Err = 1'b1; end
        endcase
      end
      T2: begin BusWires = r[y]; g_we = 1'b1; end
      T3: begin BusWires = g; rx_we = 1'b1; Done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      r    <= '0;
    end else begin
      if (rx_we) r[x] <= BusWires;
      if (a_we)  a    <= BusWires;
      if (g_we)  g    <= alu;
      case (step)
        T0: if (Run) begin
          ir   <= DIN;
          step <= T1;
        end
        default: step <= Done ? T0 : step + 2'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_multiciclo_param.sv
// Bench for proc_multiciclo_param: table of instructions with register peeks,
// per-cycle scoreboard from a reference model, and reset/illegal corner cases.
module tb_proc_multiciclo_param;
  logic        Clock = 1'b0;
  logic        Reset, Run;
  logic [15:0] DIN;
  logic        Done, Err;
  logic [15:0] BusWires;

  proc_multiciclo_param #(.N(16), .NREG(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .Done(Done), .Err(Err), .BusWires(BusWires)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] bus;
    logic        done;
    logic        err;
  } step_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] imm;
    int          peek;
    logic [15:0] val;
    string       name;
  } vec_t;

  step_t       exp_q[$];
  vec_t        vq[$];
  int          total = 0, bad = 0;
  bit          idle_chk = 1'b0;
  logic [15:0] m_r[8];
  logic [15:0] m_a, m_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge Clock) begin
    step_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("step", {14'b0, Done, Err, BusWires}, {14'b0, e.done, e.err, e.bus});
    end else if (idle_chk) begin
      chk("idle T0", {14'b0, Done, Err, BusWires}, 32'h0);
    end
  end

  // Drive one instruction, push expected per-step outputs, return T1 bus value.
  task automatic exec(input logic [15:0] ins, input logic [15:0] imm, output logic [15:0] t1_bus);
    logic [3:0]  op;
    int          x, y, n;
    logic [15:0] res;
    op = ins[15:12];
    x  = int'(ins[11:9]);
    y  = int'(ins[8:6]);
    DIN = ins; Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0; DIN = imm;
    #1 t1_bus = BusWires;
    n = 0;
    case (op)
      4'd0: begin exp_q.push_back('{m_r[y], 1'b1, 1'b0}); m_r[x] = m_r[y]; n = 1; end
      4'd1: begin exp_q.push_back('{imm, 1'b1, 1'b0}); m_r[x] = imm; n = 1; end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        exp_q.push_back('{m_r[x], 1'b0, 1'b0});
        m_a = m_r[x];
        exp_q.push_back('{m_r[y], 1'b0, 1'b0});
        case (op)
          4'd2:    res = m_a + m_r[y];
          4'd3:    res = m_a - m_r[y];
          4'd4:    res = m_a & m_r[y];
          4'd5:    res = ($signed(m_a) < $signed(m_r[y])) ? 16'd1 : 16'd0;
          default: res = m_a << m_r[y][3:0];
        endcase
        m_g = res;
        exp_q.push_back('{m_g, 1'b1, 1'b0});
        m_r[x] = m_g;
        n = 3;
      end
      4'd7: begin
        exp_q.push_back('{m_r[y], 1'b1, 1'b0});
        if (m_g != 16'h0) m_r[x] = m_r[y];
        n = 1;
      end
      default: begin exp_q.push_back('{16'h0, 1'b1, 1'b1}); n = 1; end
    endcase
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // mv Rk,Rk shows Rk on the bus in T1 without changing it.
  task automatic peek(input int k, input logic [15:0] want, input string name);
    logic [15:0] v;
    exec(16'((k << 9) | (k << 6)), 16'h0, v);
    chk(name, {16'h0, v}, {16'h0, want});
  endtask

  initial begin
    logic [15:0] t1;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_a = 16'h0; m_g = 16'h0;

    vq.push_back('{16'h1000, 16'h0005, 0, 16'h0005, "mvi r0,5"});
    vq.push_back('{16'h1200, 16'h0007, 1, 16'h0007, "mvi r1,7"});
    vq.push_back('{16'h2040, 16'h0000, 0, 16'h000C, "add r0,r1"});
    vq.push_back('{16'h1000, 16'h0005, 0, 16'h0005, "mvi r0,5 again"});
    vq.push_back('{16'h3040, 16'h0000, 0, 16'hFFFE, "sub r0,r1"});
    vq.push_back('{16'h1200, 16'h0001, 1, 16'h0001, "mvi r1,1"});
    vq.push_back('{16'h5040, 16'h0000, 0, 16'h0001, "slt r0,r1"});
    vq.push_back('{16'h1400, 16'h0003, 2, 16'h0003, "mvi r2,3"});
    vq.push_back('{16'h1600, 16'h0014, 3, 16'h0014, "mvi r3,0x14"});
    vq.push_back('{16'h64C0, 16'h0000, 2, 16'h0030, "shl r2,r3"});
    vq.push_back('{16'h3B40, 16'h0000, 5, 16'h0000, "sub r5,r5 G=0"});
    vq.push_back('{16'h7840, 16'h0000, 4, 16'h0000, "mvnz G=0"});
    vq.push_back('{16'h2C40, 16'h0000, 6, 16'h0001, "add r6,r1"});
    vq.push_back('{16'h7840, 16'h0000, 4, 16'h0001, "mvnz G!=0"});
    vq.push_back('{16'hA000, 16'h0000, 0, 16'h0001, "illegal keeps r0"});
    vq.push_back('{16'h2480, 16'h0000, 2, 16'h0060, "add r2,r2 doubles"});

    Reset = 1'b1; Run = 1'b0; DIN = 16'h0;
    repeat (2) @(posedge Clock);
    #1 chk("reset outputs", {14'b0, Done, Err, BusWires}, 32'h0);
    Reset = 1'b0;
    idle_chk = 1'b1;
    for (int k = 0; k < 8; k++) peek(k, 16'h0, $sformatf("reset r%0d", k));

    foreach (vq[i]) begin
      exec(vq[i].ins, vq[i].imm, t1);
      if (vq[i].ins[15]) begin
        chk("illegal T1 err", {30'b0, Done, Err}, 32'h0);
        chk("illegal back to T0 bus", {16'h0, BusWires}, 32'h0);
      end
      peek(vq[i].peek, vq[i].val, vq[i].name);
    end

    // Reset asserted while an add sits in T2.
    idle_chk = 1'b0;
    DIN = 16'h2040; Run = 1'b1;
    @(posedge Clock); #1 Run = 1'b0;
    chk("abort T1 bus", {16'h0, BusWires}, {16'h0, m_r[0]});
    @(posedge Clock); #1;
    chk("abort T2 bus", {15'h0, Done, BusWires}, {16'h0, m_r[1]});
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("abort reset outputs", {14'b0, Done, Err, BusWires}, 32'h0);
    Reset = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
      chk("abort stays T0", {14'b0, Done, Err, BusWires}, 32'h0);
    end
    for (int k = 0; k < 8; k++) m_r[k] = 16'h0;
    m_a = 16'h0; m_g = 16'h0;
    idle_chk = 1'b1;
    for (int k = 0; k < 8; k++) peek(k, 16'h0, $sformatf("abort r%0d", k));
    // G cleared by reset: mvnz must not write.
    exec(16'h1200, 16'h0009, t1);
    exec(16'h7840, 16'h0000, t1);
    peek(4, 16'h0, "mvnz after reset");

    @(negedge Clock);
    chk("scoreboard drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
